serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_fa_cell.sv | 13 +
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default
// operand width and the counter-width helper.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder used as the arithmetic core of the serial adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: consumes one operand bit per RUN cycle LSB first, building
// the sum MSB-down in a right-shifting register; all outputs are registered.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // A one-bit counter is still needed when WIDTH=1 (clog2 returns 0).
  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s, fa_co;

  fa_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
        carry_d          = fa_co;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flags follow the next state so they line up with the state register.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  // Operand shift registers carry only data and need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes expected results computed
// with plain integer addition; a monitor pops them on each done pulse.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the whole addition as one integer sum.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input int due);
    exp_t e;
    longint t;
    t      = longint'(x) + longint'(y) + longint'(c);
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.due  = due;
    return e;
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  logic [W-1:0] hold_sum = '0;
  logic         hold_cout = 1'b0;
  int           run_len = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        hold_sum  = '0;
        hold_cout = 1'b0;
        run_len   = 0;
      end else begin
        if (busy) run_len++;
        else if (run_len != 0) begin
          check("busy_len", run_len, W + 1);
          run_len = 0;
        end
        if (done) begin
          check("done_implies_busy", busy, 1);
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("done_cycle", cyc, e.due);
            check("sum", sum, e.sum);
            check("cout", cout, e.cout);
            hold_sum  = e.sum;
            hold_cout = e.cout;
          end
        end else if (!busy) begin
          check("hold_sum", sum, hold_sum);
          check("hold_cout", cout, hold_cout);
        end
      end
    end
  end

  // Drive a single start pulse; push expectation unless the op will be aborted.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input bit push);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    if (push) sb.push_back(model(x, y, c, cyc + 1 + W));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_idle();
    repeat (W + 1) @(negedge clk);
  endtask

  task automatic held_ops(input int n, input bit rnd);
    logic [W-1:0] x, y;
    logic         c;
    int           due;
    @(negedge clk);
    x = 8'h7F; y = 8'h01; c = 1'b0;
    a = x; b = y; cin = c; start = 1'b1;
    due = cyc + 1 + W;
    sb.push_back(model(x, y, c, due));
    for (int i = 1; i < n; i++) begin
      repeat (W + 2) @(negedge clk);
      if (rnd) begin
        x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      end
      a = x; b = y; cin = c;
      due = due + W + 2;
      sb.push_back(model(x, y, c, due));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    start_op(8'h03, 8'h05, 1'b0, 1'b1); wait_idle();
    start_op(8'hFF, 8'h01, 1'b0, 1'b1); wait_idle();
    start_op(8'hFF, 8'hFF, 1'b1, 1'b1); wait_idle();
    start_op(8'h00, 8'h00, 1'b0, 1'b1); wait_idle();
    start_op(8'h80, 8'h80, 1'b1, 1'b1); wait_idle();

    // Start pulsed during RUN must be ignored.
    start_op(8'h01, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    a = 8'h10; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);

    // Reset sampled at the end of the 4th RUN cycle aborts the operation.
    start_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);

    // Cold-start behaviour right after reset release.
    start_op(8'h03, 8'h05, 1'b0, 1'b1); wait_idle();

    held_ops(3, 1'b0);
    held_ops(4, 1'b1);

    for (int i = 0; i < 20; i++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(W + 1, W + 4)) @(negedge clk);
    end

    repeat (W + 4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
